// File: rtl/store_buffer.sv
// Posted-write buffer between the core load/store port and the platform data master.
// Defining STORE_BUFFER_FORWARD_EN lets reads hit on buffered writes instead of draining first.
module store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [29:0] ldst_addr,
    input  logic        ldst_start,
    input  logic        ldst_write,
    input  logic [31:0] ldst_data_wr,
    output logic        ldst_ready,
    output logic [31:0] ldst_data_rd,
    output logic [29:0] data_addr,
    output logic        data_start,
    output logic        data_write,
    output logic [31:0] data_data_wr,
    input  logic        data_ready,
    input  logic [31:0] data_data_rd,
    output logic        idle
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    typedef enum logic [2:0] {IDLE, WR_ISSUE, WR_WAIT, RD_ISSUE, RD_WAIT} state_t;
    state_t state_q;

    logic [29:0]   addr_mem_q [DEPTH];
    logic [31:0]   data_mem_q [DEPTH];
    logic [PW-1:0] head_q, tail_q;
    logic [CW-1:0] count_q, count_d;

    logic        pend_valid_q, pend_valid_d, pend_write_q;
    logic [29:0] pend_addr_q;
    logic [31:0] pend_data_q;

    logic        ldst_ready_q, data_start_q, data_write_q, idle_q, idle_d;
    logic [31:0] ldst_data_rd_q, data_data_wr_q;
    logic [29:0] data_addr_q;

    logic        full, enq, deq, rd_done, fwd_hit, fwd_rd, direct_wr, pend_enq, capture;
    logic [29:0] enq_addr;
    logic [31:0] enq_data, fwd_data;
`ifdef STORE_BUFFER_FORWARD_EN
    logic [PW-1:0] fwd_idx;
`endif

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        full     = (count_q == FULL_COUNT);
        fwd_hit  = 1'b0;
        fwd_data = '0;
`ifdef STORE_BUFFER_FORWARD_EN
        fwd_idx  = '0;
        // Scan oldest to youngest so the last match is the youngest write to the address.
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx = head_q + PW'(i);
            if ((CW'(i) < count_q) && (addr_mem_q[fwd_idx] == ldst_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = data_mem_q[fwd_idx];
            end
        end
`endif
        fwd_rd    = ldst_start && !ldst_write && fwd_hit;
        direct_wr = ldst_start && ldst_write && !full;
        pend_enq  = pend_valid_q && pend_write_q && !full;
        capture   = ldst_start && !direct_wr && !fwd_rd;

        enq      = pend_enq || direct_wr;
        enq_addr = pend_enq ? pend_addr_q : ldst_addr;
        enq_data = pend_enq ? pend_data_q : ldst_data_wr;
        deq      = (state_q == WR_WAIT) && data_ready;
        rd_done  = (state_q == RD_WAIT) && data_ready;
        count_d  = count_q + CW'(enq) - CW'(deq);

        pend_valid_d = pend_valid_q;
        if (capture)
            pend_valid_d = 1'b1;
        else if (pend_enq || rd_done)
            pend_valid_d = 1'b0;

        idle_d = (count_d == '0) && !pend_valid_d && ((state_q == IDLE) || deq || rd_done);
    end

    // NOTE: the entry storage has no reset; head, tail and count alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (enq) begin
            addr_mem_q[tail_q] <= enq_addr;
            data_mem_q[tail_q] <= enq_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            pend_valid_q   <= 1'b0;
            pend_write_q   <= 1'b0;
            pend_addr_q    <= '0;
            pend_data_q    <= '0;
            ldst_ready_q   <= 1'b0;
            ldst_data_rd_q <= '0;
            data_start_q   <= 1'b0;
            data_write_q   <= 1'b0;
            data_addr_q    <= '0;
            data_data_wr_q <= '0;
            idle_q         <= 1'b1;
        end else begin
            count_q      <= count_d;
            idle_q       <= idle_d;
            pend_valid_q <= pend_valid_d;
            if (enq) tail_q <= tail_q + PW'(1);
            if (deq) head_q <= head_q + PW'(1);
            if (capture) begin
                pend_write_q <= ldst_write;
                pend_addr_q  <= ldst_addr;
                pend_data_q  <= ldst_data_wr;
            end
            ldst_ready_q <= enq || fwd_rd || rd_done;
            if (fwd_rd)
                ldst_data_rd_q <= fwd_data;
            else if (rd_done)
                ldst_data_rd_q <= data_data_rd;

            // Buffered writes always win over a pending read, so reads never overtake writes.
            case (state_q)
                IDLE: begin
                    if (count_q != '0) begin
                        state_q        <= WR_ISSUE;
                        data_start_q   <= 1'b1;
                        data_write_q   <= 1'b1;
                        data_addr_q    <= addr_mem_q[head_q];
                        data_data_wr_q <= data_mem_q[head_q];
                    end else if (pend_valid_q && !pend_write_q) begin
                        state_q      <= RD_ISSUE;
                        data_start_q <= 1'b1;
                        data_write_q <= 1'b0;
                        data_addr_q  <= pend_addr_q;
                    end
                end
                WR_ISSUE: begin
                    data_start_q <= 1'b0;
                    state_q      <= WR_WAIT;
                end
                RD_ISSUE: begin
                    data_start_q <= 1'b0;
                    state_q      <= RD_WAIT;
                end
                WR_WAIT: if (data_ready) state_q <= IDLE;
                RD_WAIT: if (data_ready) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ldst_ready   = ldst_ready_q;
    assign ldst_data_rd = ldst_data_rd_q;
    assign data_addr    = data_addr_q;
    assign data_start   = data_start_q;
    assign data_write   = data_write_q;
    assign data_data_wr = data_data_wr_q;
    assign idle         = idle_q;

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed core traffic, a latency-programmable platform
// responder, and a transaction-level model checked every cycle. Honours STORE_BUFFER_FORWARD_EN.
module tb_store_buffer;
    localparam int DEPTH = 4;
`ifdef STORE_BUFFER_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [29:0] ldst_addr;
    logic        ldst_start, ldst_write;
    logic [31:0] ldst_data_wr;
    logic        ldst_ready;
    logic [31:0] ldst_data_rd;
    logic [29:0] data_addr;
    logic        data_start, data_write;
    logic [31:0] data_data_wr;
    logic        data_ready;
    logic [31:0] data_data_rd;
    logic        idle;

    always #5 clk = ~clk;

    store_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .ldst_addr(ldst_addr), .ldst_start(ldst_start), .ldst_write(ldst_write),
        .ldst_data_wr(ldst_data_wr), .ldst_ready(ldst_ready), .ldst_data_rd(ldst_data_rd),
        .data_addr(data_addr), .data_start(data_start), .data_write(data_write),
        .data_data_wr(data_data_wr), .data_ready(data_ready), .data_data_rd(data_data_rd),
        .idle(idle)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s: bound expired", name);
    endtask

    typedef struct {
        bit          wr;
        logic [29:0] addr;
        logic [31:0] data;
        int          cyc;
    } txn_t;

    // Memory contents that a platform holds before anything is written to it.
    function automatic logic [31:0] plat_init(input logic [29:0] a);
        return (a == 30'h40) ? 32'h1234_5678 : ({2'b00, a} ^ 32'h5A5A_0000);
    endfunction

    // ---------------- platform responder ----------------
    int plat_lat = 3;
    logic [31:0] plat_mem [logic [29:0]];

    initial begin
        logic [31:0] rd;
        data_ready   = 1'b0;
        data_data_rd = '0;
        forever begin
            @(negedge clk);
            if (data_start === 1'b1 && rst === 1'b0) begin
                rd = '0;
                if (data_write) plat_mem[data_addr] = data_data_wr;
                else rd = plat_mem.exists(data_addr) ? plat_mem[data_addr] : plat_init(data_addr);
                repeat (plat_lat) @(posedge clk);
                #1 data_ready = 1'b1;
                data_data_rd = rd;
                @(posedge clk);
                #1 data_ready = 1'b0;
                data_data_rd = '0;
            end
        end
    end

    // ---------------- transaction model + per-cycle compare ----------------
    int   cyc = 0;
    bit   started = 1'b0;
    txn_t exp_plat[$];
    txn_t buf_q[$];
    txn_t plat_log[$];
    int   ack_log[$];
    logic [31:0] prog_mem [logic [29:0]];
    bit   req_active, req_is_read, wait_wr_ack, read_wait, outstanding, out_wr;
    int   req_due, req_start;
    logic [31:0] req_data;
    int   last_start_cyc, last_ready_cyc;
    logic [31:0] last_rd_data;

    function automatic bit buffered_has(input logic [29:0] a);
        foreach (buf_q[i]) if (buf_q[i].addr == a) return 1'b1;
        return 1'b0;
    endfunction

    initial begin
        bit exp_idle, exp_ready;
        txn_t e;
        req_active = 0; req_is_read = 0; wait_wr_ack = 0; read_wait = 0;
        outstanding = 0; out_wr = 0; req_due = -1; req_start = 0; req_data = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst === 1'b1) begin
                started = 1'b1;
                exp_plat.delete();
                buf_q.delete();
                prog_mem.delete();
                foreach (plat_mem[k]) prog_mem[k] = plat_mem[k];
                req_active = 0; wait_wr_ack = 0; read_wait = 0; outstanding = 0;
            end else if (started) begin
                exp_idle = (buf_q.size() == 0) && !outstanding && !read_wait;
                check("idle", idle, exp_idle);
                exp_ready = req_active && (cyc == req_due);
                check("ldst_ready", ldst_ready, exp_ready);
                if (ldst_ready === 1'b1) begin
                    last_ready_cyc = cyc;
                    last_rd_data   = ldst_data_rd;
                end
                if (exp_ready) begin
                    if (req_is_read) check("ldst_data_rd", ldst_data_rd, req_data);
                    req_active = 0;
                end else if (req_active && (cyc - req_start > 1000)) begin
                    timeout_fail("core_request_completion");
                    req_active = 0;
                end

                if (ldst_start) begin
                    last_start_cyc = cyc;
                    req_active  = 1;
                    req_start   = cyc;
                    req_due     = -1;
                    req_is_read = !ldst_write;
                    if (ldst_write) begin
                        if (buf_q.size() >= DEPTH) wait_wr_ack = 1;
                        else req_due = cyc + 1;
                        buf_q.push_back('{1'b1, ldst_addr, ldst_data_wr, cyc});
                        exp_plat.push_back('{1'b1, ldst_addr, ldst_data_wr, cyc});
                        prog_mem[ldst_addr] = ldst_data_wr;
                    end else begin
                        req_data = prog_mem.exists(ldst_addr) ? prog_mem[ldst_addr] : plat_init(ldst_addr);
                        if (FWD && buffered_has(ldst_addr)) req_due = cyc + 1;
                        else begin
                            read_wait = 1;
                            exp_plat.push_back('{1'b0, ldst_addr, 32'h0, cyc});
                        end
                    end
                end

                if (data_start === 1'b1) begin
                    check("platform_one_outstanding", outstanding, 1'b0);
                    if (exp_plat.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_data_start: addr 0x%0h, no platform access expected", data_addr);
                    end else begin
                        e = exp_plat.pop_front();
                        check("plat_write", data_write, e.wr);
                        check("plat_addr", data_addr, e.addr);
                        if (e.wr) check("plat_data", data_data_wr, e.data);
                    end
                    plat_log.push_back('{data_write, data_addr, data_data_wr, cyc});
                    outstanding = 1;
                    out_wr      = data_write;
                end

                if (data_ready && outstanding) begin
                    outstanding = 0;
                    ack_log.push_back(cyc);
                    if (out_wr) begin
                        void'(buf_q.pop_front());
                        if (wait_wr_ack) begin
                            wait_wr_ack = 0;
                            req_due = cyc + 2;
                        end
                    end else begin
                        read_wait = 0;
                        req_due = cyc + 1;
                    end
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic core_req(input bit wr, input logic [29:0] a, input logic [31:0] d);
        int n;
        @(posedge clk); #1;
        ldst_start = 1'b1; ldst_write = wr; ldst_addr = a; ldst_data_wr = d;
        @(posedge clk); #1;
        ldst_start = 1'b0; ldst_write = ~wr; ldst_addr = ~a; ldst_data_wr = ~d;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ldst_ready !== 1'b1 && n < 1000);
        #1;
        if (ldst_ready !== 1'b1) timeout_fail("core_req_ready");
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (idle !== 1'b1 && n < 2000);
        #1;
        if (idle !== 1'b1) timeout_fail("wait_idle");
    endtask

    task automatic clear_logs();
        plat_log.delete();
        ack_log.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed tests ----------------
    initial begin
        int st[5];
        int rdy[5];
        rst = 1'b1; ldst_start = 1'b0; ldst_write = 1'b0; ldst_addr = '0; ldst_data_wr = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk); #1;
        check("reset_idle", idle, 1'b1);
        check("reset_ldst_ready", ldst_ready, 1'b0);
        check("reset_ldst_data_rd", ldst_data_rd, 32'h0);
        check("reset_data_start", data_start, 1'b0);
        check("reset_data_write", data_write, 1'b0);
        check("reset_data_addr", data_addr, 30'h0);
        check("reset_data_data_wr", data_data_wr, 32'h0);

        // Single write, platform latency 3.
        plat_lat = 3;
        clear_logs();
        core_req(1'b1, 30'h10, 32'hDEAD_BEEF);
        check("t1_ready_latency", last_ready_cyc - last_start_cyc, 1);
        wait_idle();
        check("t1_plat_count", plat_log.size(), 1);
        if (plat_log.size() >= 1) begin
            check("t1_plat_wr", plat_log[0].wr, 1'b1);
            check("t1_plat_addr", plat_log[0].addr, 30'h10);
            check("t1_plat_data", plat_log[0].data, 32'hDEAD_BEEF);
            check("t1_issue_cycle", plat_log[0].cyc - last_start_cyc, 2);
        end
        check("t1_idle_after_ready", idle, 1'b1);

        // Same-address writes then read: forwarded or drained.
        plat_lat = 20;
        clear_logs();
        core_req(1'b1, 30'h20, 32'h1);
        core_req(1'b1, 30'h20, 32'h2);
        core_req(1'b0, 30'h20, 32'h0);
        check("t3_read_data", last_rd_data, 32'h2);
        if (FWD) check("t3_fwd_latency", last_ready_cyc - last_start_cyc, 1);
        wait_idle();
        check("t3_plat_count", plat_log.size(), FWD ? 2 : 3);
        if (plat_log.size() >= 2) begin
            check("t3_w0_data", plat_log[0].data, 32'h1);
            check("t3_w1_data", plat_log[1].data, 32'h2);
        end
        if (!FWD && plat_log.size() >= 3) begin
            check("t3_rd_wr", plat_log[2].wr, 1'b0);
            check("t3_rd_addr", plat_log[2].addr, 30'h20);
        end

        // Buffered write, then a read miss that must wait for the drain.
        plat_lat = 5;
        clear_logs();
        core_req(1'b1, 30'h30, 32'hCAFE_0030);
        core_req(1'b0, 30'h40, 32'h0);
        check("t4_read_data", last_rd_data, 32'h1234_5678);
        wait_idle();
        check("t4_plat_count", plat_log.size(), 2);
        if (plat_log.size() >= 2 && ack_log.size() >= 1) begin
            check("t4_first_is_write", plat_log[0].addr, 30'h30);
            check("t4_second_is_read", {plat_log[1].wr, plat_log[1].addr}, {1'b0, 30'h40});
            check("t4_read_after_write_ack", plat_log[1].cyc > ack_log[0], 1'b1);
        end

        // Five back-to-back writes with latency 20; the fifth waits for the first drain.
        plat_lat = 20;
        clear_logs();
        for (int i = 0; i < 5; i++) begin
            core_req(1'b1, 30'h100 + 30'(i), 32'hA000 + 32'(i));
            st[i]  = last_start_cyc;
            rdy[i] = last_ready_cyc;
        end
        for (int i = 0; i < 4; i++) check($sformatf("t2_lat%0d", i), rdy[i] - st[i], 1);
        check("t2_lat4", rdy[4] - st[4], 16);
        if (ack_log.size() >= 1) check("t2_first_ack", ack_log[0] - st[0], 22);
        wait_idle();
        check("t2_plat_count", plat_log.size(), 5);
        for (int i = 0; i < 5 && i < plat_log.size(); i++)
            check($sformatf("t2_order%0d", i), plat_log[i].addr, 30'h100 + 30'(i));

        // Full buffer: data_ready and the new write land in the same cycle.
        plat_lat = 6;
        clear_logs();
        for (int i = 0; i < 5; i++) begin
            core_req(1'b1, 30'h200 + 30'(i), 32'hB000 + 32'(i));
            st[i]  = last_start_cyc;
            rdy[i] = last_ready_cyc;
        end
        if (ack_log.size() >= 1) check("t6_ack_same_cycle", ack_log[0], st[4]);
        check("t6_lat4", rdy[4] - st[4], 2);
        wait_idle();
        check("t6_plat_count", plat_log.size(), 5);
        for (int i = 0; i < 5 && i < plat_log.size(); i++)
            check($sformatf("t6_order%0d", i), plat_log[i].addr, 30'h200 + 30'(i));

        // Reset in WR_WAIT with three entries; the late data_ready must be ignored.
        plat_lat = 10;
        clear_logs();
        core_req(1'b1, 30'h60, 32'h60);
        core_req(1'b1, 30'h61, 32'h61);
        core_req(1'b1, 30'h62, 32'h62);
        check("t5_in_flight", plat_log.size(), 1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk); #1;
        check("t5_idle_after_rst", idle, 1'b1);
        check("t5_no_start_after_rst", data_start, 1'b0);
        clear_logs();
        repeat (15) @(negedge clk);
        #1;
        check("t5_stray_ignored_idle", idle, 1'b1);
        check("t5_no_platform_access", plat_log.size(), 0);
        core_req(1'b1, 30'h50, 32'h7);
        check("t5_write_latency", last_ready_cyc - last_start_cyc, 1);
        wait_idle();
        check("t5_plat_count", plat_log.size(), 1);
        if (plat_log.size() >= 1)
            check("t5_plat_txn", {plat_log[0].wr, plat_log[0].addr, plat_log[0].data}, {1'b1, 30'h50, 32'h7});

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
